// File: rtl/config_hub_pkg.sv
// Shared types and constants for the config_hub AXI4-Lite register hub.
package config_hub_pkg;

  localparam int AXI_ADDR_BITS  = 32;
  localparam int AXIL_DATA_BITS = 64;
  localparam int STRB_BITS      = AXIL_DATA_BITS / 8;
  localparam int ADDR_LSB       = $clog2(STRB_BITS);
  localparam int DEF_ADDR_TOP   = 64;
  localparam int CFG_ADDR_BITS  = $clog2(DEF_ADDR_TOP);
  localparam int WR_COUNT_BITS  = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  function automatic int addr_bits(input int top);
    return (top < 2) ? 1 : $clog2(top);
  endfunction

  function automatic logic [AXIL_DATA_BITS-1:0] strb_mask(
    input logic [STRB_BITS-1:0]      strb,
    input logic [AXIL_DATA_BITS-1:0] data
  );
    logic [AXIL_DATA_BITS-1:0] o;
    o = '0;
    for (int b = 0; b < STRB_BITS; b++) begin
      o[8*b +: 8] = strb[b] ? data[8*b +: 8] : 8'h00;
    end
    return o;
  endfunction

endpackage

// File: rtl/config_hub_pipe.sv
// config_pipe: fixed-latency delay line for one config channel.
// Top bit of the word is the valid flag; only it is reset.
module config_pipe
  import config_hub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  if (DEPTH == 0) begin : g_wire
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst;
    assign o_data = i_data;
  end else begin : g_reg
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-2:0] r_payload [DEPTH];

    always_ff @(posedge clk) begin
      if (rst) begin
        r_valid <= '0;
      end else begin
        r_valid[0] <= i_data[WIDTH-1];
        for (int k = 1; k < DEPTH; k++) begin
          r_valid[k] <= r_valid[k-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      r_payload[0] <= i_data[WIDTH-2:0];
      for (int k = 1; k < DEPTH; k++) begin
        r_payload[k] <= r_payload[k-1];
      end
    end

    assign o_data = {r_valid[DEPTH-1], r_payload[DEPTH-1]};
  end

endmodule

// File: rtl/config_hub.sv
// AXI4-Lite slave fanning writes out to config channels, reads from status.
// Define CONFIG_HUB_WR_COUNT_EN to expose an emitted-message counter.
module config_hub
  import config_hub_pkg::*;
#(
  parameter int NUM_CONFIGS = 4,
  parameter int ADDR_SPACE_BOUNDS [NUM_CONFIGS+1] = '{0, 16, 32, 48, 64},
  parameter int NUM_STATUS  = 4,
  parameter int STATUS_BASE = 256,
  parameter int PIPE_LEVELS = 1,
  localparam int CAW = addr_bits(ADDR_SPACE_BOUNDS[NUM_CONFIGS])
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [AXI_ADDR_BITS-1:0] i_axi_awaddr,
  input  logic                     i_axi_awvalid,
  output logic                     o_axi_awready,
  input  logic [AXIL_DATA_BITS-1:0] i_axi_wdata,
  input  logic [STRB_BITS-1:0]     i_axi_wstrb,
  input  logic                     i_axi_wvalid,
  output logic                     o_axi_wready,
  output logic [1:0]               o_axi_bresp,
  output logic                     o_axi_bvalid,
  input  logic                     i_axi_bready,
  input  logic [AXI_ADDR_BITS-1:0] i_axi_araddr,
  input  logic                     i_axi_arvalid,
  output logic                     o_axi_arready,
  output logic [AXIL_DATA_BITS-1:0] o_axi_rdata,
  output logic [1:0]               o_axi_rresp,
  output logic                     o_axi_rvalid,
  input  logic                     i_axi_rready,
  output logic [NUM_CONFIGS-1:0][CAW-1:0]            o_cfg_addr,
  output logic [NUM_CONFIGS-1:0][AXIL_DATA_BITS-1:0] o_cfg_data,
  output logic [NUM_CONFIGS-1:0]                     o_cfg_valid,
  input  logic [NUM_STATUS-1:0][AXIL_DATA_BITS-1:0]  i_status_in
);

  localparam int DW   = AXIL_DATA_BITS;
  localparam int IDXW = AXI_ADDR_BITS - ADDR_LSB;
  localparam int PW   = CAW + DW + 1;

  for (genvar g = 0; g < NUM_CONFIGS; g++) begin : g_chk
    if (ADDR_SPACE_BOUNDS[g] >= ADDR_SPACE_BOUNDS[g+1]) begin : g_bad
      $error("config_hub: ADDR_SPACE_BOUNDS not strictly ascending");
    end
  end

  if (STATUS_BASE < ADDR_SPACE_BOUNDS[NUM_CONFIGS] &&
      STATUS_BASE + NUM_STATUS > ADDR_SPACE_BOUNDS[0]) begin : g_ovl
    $error("config_hub: status window overlaps config windows");
  end

  logic w_unused_bits;
  assign w_unused_bits = ^{i_axi_awaddr[ADDR_LSB-1:0],
                           i_axi_araddr[ADDR_LSB-1:0]};

  w_state_e r_wstate;
  w_state_e w_wstate_nxt;
  logic     r_aw_held;
  logic     r_w_held;
  logic [IDXW-1:0]      r_awidx;
  logic [DW-1:0]        r_wdata;
  logic [STRB_BITS-1:0] r_wstrb;
  logic [1:0]           r_bresp;

  logic [NUM_CONFIGS-1:0] r_msg_valid;
  logic [CAW-1:0]         r_msg_addr;
  logic [DW-1:0]          r_msg_data;

  logic w_aw_hs;
  logic w_w_hs;
  logic w_both;
  logic w_commit;
  logic [31:0]            w_widx;
  logic [NUM_CONFIGS-1:0] w_hit;
  logic [CAW-1:0]         w_hit_addr;

  assign o_axi_awready = !rst && r_wstate == W_IDLE && !r_aw_held;
  assign o_axi_wready  = !rst && r_wstate == W_IDLE && !r_w_held;
  assign o_axi_bvalid  = r_wstate == W_RESP;
  assign o_axi_bresp   = r_bresp;

  assign w_aw_hs  = i_axi_awvalid && o_axi_awready;
  assign w_w_hs   = i_axi_wvalid && o_axi_wready;
  assign w_both   = r_aw_held && r_w_held;
  assign w_commit = r_wstate == W_IDLE && w_both;
  assign w_widx   = 32'(r_awidx);

  always_comb begin
    w_hit      = '0;
    w_hit_addr = '0;
    for (int i = 0; i < NUM_CONFIGS; i++) begin
      if (w_widx >= 32'(ADDR_SPACE_BOUNDS[i]) &&
          w_widx <  32'(ADDR_SPACE_BOUNDS[i+1])) begin
        w_hit[i]   = 1'b1;
        w_hit_addr = CAW'(w_widx - 32'(ADDR_SPACE_BOUNDS[i]));
      end
    end
  end

  always_comb begin
    w_wstate_nxt = r_wstate;
    unique case (r_wstate)
      W_IDLE: if (w_both) w_wstate_nxt = W_RESP;
      W_RESP: if (i_axi_bready) w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wstate    <= W_IDLE;
      r_aw_held   <= 1'b0;
      r_w_held    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_msg_valid <= '0;
    end else begin
      r_wstate    <= w_wstate_nxt;
      r_msg_valid <= '0;
      if (w_aw_hs) r_aw_held <= 1'b1;
      if (w_w_hs)  r_w_held  <= 1'b1;
      if (w_commit) begin
        r_aw_held   <= 1'b0;
        r_w_held    <= 1'b0;
        r_bresp     <= (|w_hit) ? RESP_OKAY : RESP_SLVERR;
        // An all-zero strobe is acknowledged but carries nothing.
        r_msg_valid <= w_hit & {NUM_CONFIGS{|r_wstrb}};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_aw_hs) r_awidx <= i_axi_awaddr[AXI_ADDR_BITS-1:ADDR_LSB];
    if (w_w_hs) begin
      r_wdata <= i_axi_wdata;
      r_wstrb <= i_axi_wstrb;
    end
    if (w_commit) begin
      r_msg_addr <= w_hit_addr;
      r_msg_data <= strb_mask(r_wstrb, r_wdata);
    end
  end

  logic [NUM_CONFIGS-1:0][PW-1:0] w_pipe_out;

  for (genvar g = 0; g < NUM_CONFIGS; g++) begin : g_ch
    config_pipe #(
      .WIDTH (PW),
      .DEPTH (PIPE_LEVELS)
    ) u_pipe (
      .clk    (clk),
      .rst    (rst),
      .i_data ({r_msg_valid[g], r_msg_addr, r_msg_data}),
      .o_data (w_pipe_out[g])
    );
    assign o_cfg_valid[g] = w_pipe_out[g][PW-1];
    assign o_cfg_addr[g]  = w_pipe_out[g][PW-2 -: CAW];
    assign o_cfg_data[g]  = w_pipe_out[g][DW-1:0];
  end

`ifdef CONFIG_HUB_WR_COUNT_EN
  logic [WR_COUNT_BITS-1:0] r_wr_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_count <= '0;
    end else if (|o_cfg_valid) begin
      r_wr_count <= r_wr_count + 1'b1;
    end
  end
`endif

  r_state_e r_rstate;
  r_state_e w_rstate_nxt;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_rresp;
  logic [DW-1:0] w_rdata_nxt;
  logic [1:0]    w_rresp_nxt;
  logic [31:0]   w_ridx;
  logic          w_ar_hs;

  assign o_axi_arready = !rst && r_rstate == R_IDLE;
  assign o_axi_rvalid  = r_rstate == R_DATA;
  assign o_axi_rdata   = r_rdata;
  assign o_axi_rresp   = r_rresp;
  assign w_ar_hs       = i_axi_arvalid && o_axi_arready;
  assign w_ridx        = 32'(i_axi_araddr[AXI_ADDR_BITS-1:ADDR_LSB]);

  always_comb begin
    w_rdata_nxt = '0;
    w_rresp_nxt = RESP_SLVERR;
    for (int k = 0; k < NUM_STATUS; k++) begin
      if (w_ridx == 32'(STATUS_BASE + k)) begin
        w_rdata_nxt = i_status_in[k];
        w_rresp_nxt = RESP_OKAY;
      end
    end
`ifdef CONFIG_HUB_WR_COUNT_EN
    if (w_ridx == 32'(STATUS_BASE + NUM_STATUS)) begin
      w_rdata_nxt = DW'(r_wr_count);
      w_rresp_nxt = RESP_OKAY;
    end
`endif
  end

  always_comb begin
    w_rstate_nxt = r_rstate;
    unique case (r_rstate)
      R_IDLE: if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA: if (i_axi_rready) w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rdata  <= '0;
      r_rresp  <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_nxt;
      if (w_ar_hs) begin
        r_rdata <= w_rdata_nxt;
        r_rresp <= w_rresp_nxt;
      end
    end
  end

endmodule
